// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a granted client holds the grant for up to its
// programmed weight in non-stalled cycles, then priority rotates past it.
module wrr_arbiter #(
    parameter int unsigned CLIENTS  = 8,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CLIENTS-1:0]            request,
    input  logic [CLIENTS*WEIGHT_W-1:0]   weight,
    input  logic                          stall,
    output logic [CLIENTS-1:0]            grant,
    output logic                          grant_valid,
    output logic [$clog2(CLIENTS)-1:0]    grant_id,
    output logic                          burst_last
);

    localparam int unsigned ID_W = $clog2(CLIENTS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CLIENTS-1:0]  grant_nxt;
    logic [ID_W-1:0]     id_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [WEIGHT_W-1:0] cnt, cnt_nxt;
    logic                valid_nxt;
    logic                last_nxt;

    logic                found;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     win_succ;
    logic [WEIGHT_W-1:0] win_weight;
    logic [WEIGHT_W-1:0] win_eff;
    int unsigned         idx;

    // First requester at or above ptr, wrapping; ptr always equals (last grantee + 1).
    always_comb begin : find_winner
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < CLIENTS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= CLIENTS) begin
                idx = idx - CLIENTS;
            end
            if (!found && request[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin : winner_attrs
        win_weight = weight[32'(win)*WEIGHT_W +: WEIGHT_W];
        win_eff    = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
        win_succ   = (win == ID_W'(CLIENTS - 1)) ? '0 : win + ID_W'(1);
    end

    // Next-state: hold on stall, count down a live burst, otherwise re-arbitrate.
    always_comb begin : next_state
        logic arb;
        state_nxt = state;
        grant_nxt = grant;
        id_nxt    = grant_id;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        arb       = 1'b0;

        if (!stall) begin
            case (state)
                IDLE: arb = 1'b1;
                GRANT: begin
                    if (request[grant_id] && (cnt > WEIGHT_W'(1))) begin
                        cnt_nxt = cnt - WEIGHT_W'(1);
                    end else begin
                        arb = 1'b1;
                    end
                end
                default: arb = 1'b1;
            endcase
        end

        if (arb) begin
            if (found) begin
                state_nxt = GRANT;
                grant_nxt = CLIENTS'(1) << win;
                id_nxt    = win;
                cnt_nxt   = win_eff;
                ptr_nxt   = win_succ;
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
                id_nxt    = '0;
                cnt_nxt   = '0;
            end
        end

        valid_nxt = (state_nxt == GRANT);
        last_nxt  = valid_nxt && (cnt_nxt == WEIGHT_W'(1));
    end

    always_ff @(posedge clock or negedge reset) begin : regs
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            burst_last  <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
            grant_id    <= id_nxt;
            burst_last  <= last_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: hand-computed grant sequences checked each cycle.
module tb_wrr_arbiter;

    localparam int unsigned CLIENTS  = 8;
    localparam int unsigned WEIGHT_W = 4;
    localparam int unsigned ID_W     = 3;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic [CLIENTS-1:0]          request = '0;
    logic [CLIENTS*WEIGHT_W-1:0] weight = '0;
    logic                        stall = 1'b0;
    logic [CLIENTS-1:0]          grant;
    logic                        grant_valid;
    logic [ID_W-1:0]             grant_id;
    logic                        burst_last;

    int passed = 0;
    int total  = 0;

    int unsigned t2_id [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    int unsigned t2_bl [10] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};

    wrr_arbiter #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .weight      (weight),
        .stall       (stall),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_last  (burst_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] g, input int unsigned id,
                                 input logic bl);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
        check({tag, ".burst_last"}, 32'(burst_last), 32'(bl));
        check({tag, ".grant_valid"}, 32'(grant_valid), 32'(g != 8'h00));
    endtask

    // Advance one cycle and check outputs away from the active edge.
    task automatic step_check(input string tag, input logic [7:0] g, input int unsigned id,
                              input logic bl);
        @(negedge clock);
        check_outputs(tag, g, id, bl);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b0;
        request = '0;
        stall   = 1'b0;
        weight  = {CLIENTS{4'h1}};
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #1;
        check_outputs("reset", 8'h00, 0, 1'b0);

        // 1: unit weights, all requesting -> plain rotation
        do_reset();
        request = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step_check("t1", 8'(1 << (i % 8)), i % 8, 1'b1);
        end

        // 2: weights 3/2 on clients 0/1
        do_reset();
        weight[0*WEIGHT_W +: WEIGHT_W] = 4'd3;
        weight[1*WEIGHT_W +: WEIGHT_W] = 4'd2;
        request = 8'h03;
        for (int i = 0; i < 10; i++) begin
            step_check("t2", 8'(1 << t2_id[i]), t2_id[i], t2_bl[i][0]);
        end

        // 3: stall in client 0's second burst cycle
        do_reset();
        weight[0*WEIGHT_W +: WEIGHT_W] = 4'd3;
        weight[1*WEIGHT_W +: WEIGHT_W] = 4'd2;
        request = 8'h03;
        step_check("t3_c1", 8'h01, 0, 1'b0);
        step_check("t3_c2", 8'h01, 0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_check("t3_stall", 8'h01, 0, 1'b0);
        end
        stall = 1'b0;
        step_check("t3_c3", 8'h01, 0, 1'b1);
        step_check("t3_g1a", 8'h02, 1, 1'b0);
        step_check("t3_g1b", 8'h02, 1, 1'b1);

        // 4: withdrawal mid-burst hands over immediately
        do_reset();
        weight[2*WEIGHT_W +: WEIGHT_W] = 4'd5;
        weight[5*WEIGHT_W +: WEIGHT_W] = 4'd3;
        request = 8'h24;
        step_check("t4_a", 8'h04, 2, 1'b0);
        step_check("t4_b", 8'h04, 2, 1'b0);
        request = 8'h20;
        step_check("t4_c", 8'h20, 5, 1'b0);
        step_check("t4_d", 8'h20, 5, 1'b0);
        step_check("t4_e", 8'h20, 5, 1'b1);
        step_check("t4_f", 8'h20, 5, 1'b0);

        // 5: zero weight behaves as one; drop goes idle
        do_reset();
        weight[3*WEIGHT_W +: WEIGHT_W] = 4'd0;
        request = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step_check("t5_hold", 8'h08, 3, 1'b1);
        end
        request = 8'h00;
        step_check("t5_idle", 8'h00, 0, 1'b0);
        step_check("t5_idle2", 8'h00, 0, 1'b0);

        // 6: asynchronous reset mid-burst, then search restarts at client 0
        do_reset();
        weight[5*WEIGHT_W +: WEIGHT_W] = 4'd4;
        request = 8'h20;
        step_check("t6_a", 8'h20, 5, 1'b0);
        step_check("t6_b", 8'h20, 5, 1'b0);
        reset = 1'b0;
        #1;
        check_outputs("t6_async", 8'h00, 0, 1'b0);
        @(negedge clock);
        check_outputs("t6_held", 8'h00, 0, 1'b0);
        reset   = 1'b1;
        request = 8'h90;
        step_check("t6_first", 8'h10, 4, 1'b1);
        step_check("t6_next", 8'h80, 7, 1'b1);
        step_check("t6_wrap", 8'h10, 4, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
